rstack_ctrl: RTL
================

# rstack_ctrl

Return-stack controller for the CPU: accepts push/pop requests from the control unit (call/return), keeps the top entry in a register, and spills deeper entries into the `rstack` memory through its async-read / sync-write port. Single-cycle push, pop and replace, with depth tracking and sticky overflow/underflow flags. Sits between the CPU control unit and the `rstack` instance.

## Interface
- `WIDTH`, 13: memory address width.
- `SIZE`, 8192: total stack capacity in entries, register plus memory. Requires `2 <= SIZE <= 2**WIDTH`.
- `DATA_WIDTH`, 16: entry width.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `push` input 1: push request this cycle.
- `pop` input 1: pop request this cycle.
- `push_data` input DATA_WIDTH: value to push.
- `clear_err` input 1: clears the sticky error flags.
- `top` output DATA_WIDTH: current top entry, registered. Reads 0 when the stack is empty.
- `depth` output WIDTH+1: number of entries held, 0..SIZE.
- `empty` output 1: `depth == 0`.
- `full` output 1: `depth == SIZE`.
- `overflow` output 1: sticky; set by a rejected push.
- `underflow` output 1: sticky; set by a rejected pop.
- `mem_dout_addr` output WIDTH: read address to `rstack`.
- `mem_dout` input DATA_WIDTH: async read data from `rstack`.
- `we` output 1: write enable to `rstack`.
- `mem_din_addr` output WIDTH: write address to `rstack`.
- `mem_din` output DATA_WIDTH: write data to `rstack`.

## Operation
**Storage model**
- The top entry lives in the `tos` register.
- Entries below the top live in memory at addresses 0..depth-2, with the oldest entry at address 0.
- Memory usage never exceeds SIZE-1 words.

**Combinational memory outputs**
- `mem_dout_addr` = depth-2 when depth >= 2; otherwise 0.
- `mem_din_addr` = depth-1 when depth >= 1; otherwise 0. Truncated to WIDTH bits.
- `mem_din` = `tos`.
- `we` is asserted only for an accepted plain push with depth >= 1.

**Per-cycle actions, priority in listed order**
1. push && pop, depth == 0: rejected. `underflow` <= 1; no state change; `we` = 0.
2. push && pop, depth >= 1 (replace): `tos` <= `push_data`; depth unchanged; `we` = 0; no error, including when full.
3. push only, full: rejected. `overflow` <= 1; no state change; `we` = 0.
4. push only, depth == 0: `tos` <= `push_data`; depth <= 1; `we` = 0.
5. push only, 1 <= depth < SIZE: `we` = 1, writing `tos` to mem[depth-1]; `tos` <= `push_data`; depth <= depth+1.
6. pop only, depth == 0: rejected. `underflow` <= 1; `tos` stays 0.
7. pop only, depth == 1: `tos` <= 0; depth <= 0.
8. pop only, depth >= 2: `tos` <= `mem_dout`, read from mem[depth-2]; depth <= depth-1.
9. Neither: hold.

**Error flags**
- A rising edge with `clear_err` = 1 clears both flags.
- If a rejection occurs in the same cycle as `clear_err`, the corresponding flag ends the cycle set (the error wins).
- Flags never clear on their own.

## Timing
- Reset, asynchronous and effective immediately:
  - `tos` = 0, depth = 0, `overflow` = `underflow` = 0.
  - Outputs therefore read `top` = 0, `depth` = 0, `empty` = 1, `full` = 0.
  - Combinational outputs: `we` = 0, `mem_din_addr` = 0, `mem_dout_addr` = 0, `mem_din` = 0.
  - Memory contents are not cleared; stale words are never exposed because reads only target addresses below depth-1.
- Reset mid-operation: any write in flight is suppressed the moment `reset` asserts, because `we` is derived from depth = 0.
- Latency: `top`, `depth`, `empty` and `full` reflect a push, pop or replace one edge after the request. A pop needs no extra read cycle because the memory read is async.
- Throughput: one operation per cycle, back-to-back in any mix with no bubbles.
- There is no handshake: requests are sampled every edge. A rejected request is dropped, not retried.
- `top` is registered. `empty`, `full` and the memory-side outputs are combinational from registers only; none are combinational from `push`, `pop` or `push_data` except `we`.

## Test plan
- **Basic LIFO (SIZE=8):** after reset, push 0x1111, 0x2222, 0x3333 on consecutive cycles.
  - Required: depth=3, `top`=0x3333; mem[0]=0x1111, mem[1]=0x2222.
  - Then three pops return `top`=0x2222, 0x1111, 0, and `empty`=1.
- **Overflow (SIZE=4):** push 1..5.
  - Required: `full`=1 after the 4th push; the 5th is ignored with `overflow`=1, `top`=4, depth=4.
  - Then push&&pop with 0xAAAA gives `top`=0xAAAA, depth=4, and `overflow` stays 1.
- **Underflow:** from reset, pop.
  - Required: `underflow`=1, depth=0, `top`=0.
  - Then push&&pop on empty leaves depth=0 and `top`=0.
- **Flag clearing:** with `underflow`=1, assert `clear_err` alone, which clears the flag. Then assert pop on empty together with `clear_err`.
  - Required: `underflow`=1 after that edge.
- **Replace and mixed streams:** push A, push B, replace with C, pop.
  - Required: `top`=A, depth=1; `we` is asserted only on the second push, at address 0.
- **Reset mid-operation:** with depth=3, assert `reset` asynchronously mid-cycle while push is high.
  - Required: outputs reset immediately, `we`=0, no memory write at that edge.
  - After release, push 0x5 gives depth=1, `top`=0x5.

Source files
------------

// File: rtl/rstack_ctrl.sv
// rstack_ctrl: return-stack controller with the top entry held in a register
// and deeper entries spilled to an async-read / sync-write memory.
`default_nettype none

module rstack_ctrl #(
  parameter int WIDTH      = 13,
  parameter int SIZE       = 8192,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] top,
  output logic [WIDTH:0]        depth,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow,
  output logic [WIDTH-1:0]      mem_dout_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  we,
  output logic [WIDTH-1:0]      mem_din_addr,
  output logic [DATA_WIDTH-1:0] mem_din
);

  localparam logic [WIDTH:0]   DEPTH_MAX = (WIDTH+1)'(SIZE);
  localparam logic [WIDTH:0]   DEPTH_ONE = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   DEPTH_TWO = (WIDTH+1)'(2);
  localparam logic [WIDTH-1:0] ADDR_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ADDR_TWO  = WIDTH'(2);

  logic [DATA_WIDTH-1:0] tos_q, tos_d;
  logic [WIDTH:0]        depth_q, depth_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  is_empty;
  logic                  is_full;
  logic [WIDTH-1:0]      addr_m1;
  logic [WIDTH-1:0]      addr_m2;

  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == DEPTH_MAX);

  // Address arithmetic is done modulo 2**WIDTH; results are only used while
  // depth is large enough that they never wrap.
  assign addr_m1 = depth_q[WIDTH-1:0] - ADDR_ONE;
  assign addr_m2 = depth_q[WIDTH-1:0] - ADDR_TWO;

  assign mem_dout_addr = (depth_q >= DEPTH_TWO) ? addr_m2 : '0;
  assign mem_din_addr  = is_empty ? '0 : addr_m1;
  assign mem_din       = tos_q;
  assign we            = push & ~pop & ~is_empty & ~is_full;

  assign top       = tos_q;
  assign depth     = depth_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  always_comb begin
    tos_d   = tos_q;
    depth_d = depth_q;
    // Clear first so a rejection in the same cycle leaves its flag set.
    ovf_d   = ovf_q & ~clear_err;
    unf_d   = unf_q & ~clear_err;

    if (push && pop) begin
      if (is_empty) begin
        unf_d = 1'b1;
      end else begin
        tos_d = push_data;
      end
    end else if (push) begin
      if (is_full) begin
        ovf_d = 1'b1;
      end else begin
        tos_d   = push_data;
        depth_d = depth_q + DEPTH_ONE;
      end
    end else if (pop) begin
      if (is_empty) begin
        unf_d = 1'b1;
      end else if (depth_q == DEPTH_ONE) begin
        tos_d   = '0;
        depth_d = '0;
      end else begin
        tos_d   = mem_dout;
        depth_d = depth_q - DEPTH_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tos_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tos_q   <= tos_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

endmodule

`default_nettype wire
